// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/clear buttons, an
// IDLE/RUN/PAUSE state machine, a 3-digit BCD seconds count with lap freeze,
// and a 3-way digit scan for a multiplexed display.
module stopwatch_ctrl #(
  parameter int DEFAULT_CLK     = 100000000,
  parameter int TICK_FREQ       = 1,
  parameter int REFRESH_FREQ    = 10000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_startStop,
  input  logic       i_lapClear,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit2,
  output logic [3:0] o_digit3,
  output logic [3:0] o_digit,
  output logic [1:0] o_refreshSel,
  output logic       o_running,
  output logic       o_lapHold
);

  localparam int TICK_DIV = DEFAULT_CLK / TICK_FREQ;
  localparam int REF_DIV  = DEFAULT_CLK / REFRESH_FREQ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int REF_W    = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REF_DIV - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Increment a 3-digit BCD value {d3,d2,d1}; 999 rolls over to 000.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4] = 4'd0;
        if (v[11:8] == 4'd9) begin
          r[11:8] = 4'd0;
        end else begin
          r[11:8] = v[11:8] + 4'd1;
        end
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Index 0 is start/stop, index 1 is lap/clear.
  logic [1:0]      btn_raw_s;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      samp_q;
  logic [1:0]      level_q, level_d;
  logic [1:0]      armed_q, armed_d;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      stable_s;

  logic              ready_q;
  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [11:0]       count_q, count_d;
  logic [11:0]       lap_val_q, lap_val_d;
  logic              lap_hold_q, lap_hold_d;
  logic [11:0]       disp_q, disp_d;
  logic              running_q, running_d;
  logic              tick_s;
  logic              clear_s;
  logic              ss_press_s, lc_press_s;

  assign btn_raw_s  = {i_lapClear, i_startStop};
  assign ss_press_s = press_q[0];
  assign lc_press_s = press_q[1];

  // Retime reset release: the rest of the logic first acts on the second edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Debounce: accept a level after DEBOUNCE_CYCLES identical samples; a rising
  // accepted level only counts as a press once a released level has been seen.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = DB_W'(1);
      if (sync2_q[b] == samp_q[b]) begin
        if (db_cnt_q[b] == DB_MAX) begin
          db_cnt_d[b] = DB_MAX;
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end else begin
        db_cnt_d[b] = DB_W'(1);
      end
      stable_s[b] = (db_cnt_d[b] == DB_MAX);
      level_d[b]  = stable_s[b] ? sync2_q[b] : level_q[b];
      armed_d[b]  = armed_q[b] | (stable_s[b] & ~sync2_q[b]);
      press_d[b]  = level_d[b] & ~level_q[b] & armed_q[b];
    end
  end

  // Button synchronizers and debouncer state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      samp_q  <= 2'b00;
      level_q <= 2'b00;
      armed_q <= 2'b00;
      press_q <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b] <= {DB_W{1'b0}};
      end
    end else if (ready_q) begin
      sync1_q <= btn_raw_s;
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b] <= db_cnt_d[b];
      end
    end
  end

  // Mode FSM next state, lap hold and clear decisions; start/stop has priority.
  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    lap_val_d  = lap_val_q;
    clear_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_press_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ss_press_s) begin
          state_d = ST_PAUSE;
        end else if (lc_press_s) begin
          lap_hold_d = ~lap_hold_q;
          if (!lap_hold_q) begin
            lap_val_d = count_q;
          end else begin
            lap_val_d = lap_val_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ss_press_s) begin
          state_d = ST_RUN;
        end else if (lc_press_s) begin
          state_d    = ST_IDLE;
          lap_hold_d = 1'b0;
          clear_s    = 1'b1;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lap_hold_d = 1'b0;
        clear_s    = 1'b1;
      end
    endcase
  end

  // Tick prescaler, BCD count, display value and scan step.
  always_comb begin
    tick_s     = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (tick_s) begin
          tick_cnt_d = {TICK_W{1'b0}};
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      ST_PAUSE: tick_cnt_d = tick_cnt_q;
      default:  tick_cnt_d = {TICK_W{1'b0}};
    endcase

    if (clear_s) begin
      count_d = 12'd0;
    end else if (tick_s) begin
      count_d = bcd_inc(count_q);
    end else begin
      count_d = count_q;
    end

    disp_d    = lap_hold_d ? lap_val_d : count_d;
    running_d = (state_d == ST_RUN);

    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = {REF_W{1'b0}};
      if (sel_q == 2'd2) begin
        sel_d = 2'd0;
      end else begin
        sel_d = sel_q + 2'd1;
      end
    end else begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
      sel_d     = sel_q;
    end
  end

  // Core state registers; outputs are taken straight from these.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= {TICK_W{1'b0}};
      ref_cnt_q  <= {REF_W{1'b0}};
      sel_q      <= 2'd0;
      count_q    <= 12'd0;
      lap_val_q  <= 12'd0;
      lap_hold_q <= 1'b0;
      disp_q     <= 12'd0;
      running_q  <= 1'b0;
    end else if (ready_q) begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      lap_val_q  <= lap_val_d;
      lap_hold_q <= lap_hold_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
    end
  end

  // Scan multiplexer selecting the digit currently being driven.
  always_comb begin
    o_digit = 4'd0;
    case (sel_q)
      2'd0:    o_digit = disp_q[3:0];
      2'd1:    o_digit = disp_q[7:4];
      2'd2:    o_digit = disp_q[11:8];
      default: o_digit = 4'd0;
    endcase
  end

  assign o_digit1     = disp_q[3:0];
  assign o_digit2     = disp_q[7:4];
  assign o_digit3     = disp_q[11:8];
  assign o_refreshSel = sel_q;
  assign o_running    = running_q;
  assign o_lapHold    = lap_hold_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEFAULT_CLK, default 100000000: i_clk frequency in Hz.
REQ-002 Parameter TICK_FREQ, default 1: count-tick rate in Hz.
REQ-003 Parameter REFRESH_FREQ, default 10000: digit-scan step rate in Hz.
REQ-004 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable i_clk cycles required to accept a button level.
REQ-005 i_clk  input  1  sole clock, all logic on rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-low.
REQ-007 i_startStop  input  1  raw start/stop button, asynchronous, active-high.
REQ-008 i_lapClear  input  1  raw lap/clear button, asynchronous, active-high.
REQ-009 o_digit1 / o_digit2 / o_digit3  output  4 each  displayed BCD digits; digit1 is least significant.
REQ-010 o_digit  output  4  BCD digit currently selected by the scan.
REQ-011 o_refreshSel  output  2  scan index 0..2.
REQ-012 o_running  output  1  high in RUN state.
REQ-013 o_lapHold  output  1  high while the display is frozen on a lap value.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
- Accepted level updates only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
- A 0->1 change of the accepted level SHALL produce a press pulse exactly one cycle wide.
REQ-015 FSM states SHALL be IDLE, RUN and PAUSE; reset state is IDLE.
REQ-016 Start/stop press transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-017 Lap/clear press in RUN SHALL toggle o_lapHold; counting continues.
REQ-018 Lap/clear press in PAUSE SHALL go to IDLE, zero all digits and clear o_lapHold.
REQ-019 Lap/clear press in IDLE SHALL have no effect.
REQ-020 If both press pulses occur in the same cycle, start/stop SHALL win and lap/clear SHALL be discarded.
REQ-021 Tick prescaler SHALL count 0..DEFAULT_CLK/TICK_FREQ-1 and emit a one-cycle tick at terminal count.
- It advances only in RUN.
- It holds its value in PAUSE, so the phase is preserved.
- It is zeroed in IDLE.
REQ-022 Each tick SHALL increment the 3-digit BCD count.
- A digit at 9 SHALL wrap to 0 and carry into the next digit.
- 999 SHALL wrap to 000 with no flag.
REQ-023 A tick in the same cycle as a RUN->PAUSE press SHALL still be counted.
REQ-024 Entering lap hold SHALL latch the current count in that cycle.
- While o_lapHold=1, o_digit1..3 SHALL show the latched value.
- Otherwise o_digit1..3 SHALL show the live count.
REQ-025 Refresh prescaler SHALL count 0..DEFAULT_CLK/REFRESH_FREQ-1 in every state.
- Each terminal count SHALL step o_refreshSel 0->1->2->0.
- Value 3 SHALL never appear.
REQ-026 o_digit SHALL be combinational: o_digit1 when o_refreshSel=0, o_digit2 when 1, o_digit3 when 2.
REQ-027 All outputs other than o_digit SHALL be registered.

Reset
REQ-028 i_rst low SHALL immediately force:
- state IDLE;
- both prescalers, BCD count and lap latch to 0;
- o_refreshSel=0, o_running=0, o_lapHold=0;
- synchronizers, debouncers and accepted levels to 0.
REQ-029 Reset asserted mid-RUN or mid-lap-hold SHALL fully abandon the operation.
- No press SHALL be generated on deassertion, even if a button is held.
- A held button must be released and pressed again to act.
REQ-030 Release of i_rst SHALL be synchronized internally; operation SHALL start on the second i_clk edge after release.

Verification
All scenarios use DEFAULT_CLK=1000, TICK_FREQ=100 (10 cycles/tick), REFRESH_FREQ=250 (4 cycles/step), DEBOUNCE_CYCLES=4.
REQ-031 Bounce: toggle i_startStop every 2 cycles for 20 cycles, then hold high for 10 cycles -> exactly one press and o_running=1; the bounce phase produces none.
REQ-032 Count/carry: RUN for 100 ticks -> digits 1,0,0 (digit3..1 = 1,0,0).
- Preload by running 999 ticks, then one more tick -> 0,0,0 with carry chain correct.
REQ-033 Pause: press start/stop at count 5 with the prescaler at 7, wait 50 cycles -> count stays 5.
- Press again -> next tick arrives 3 cycles after RUN is re-entered.
REQ-034 Lap: press lap at count 12, run 30 more ticks -> o_digit shows 12 while the live count reaches 42.
- Press lap again -> display shows 42.
- Pause, then press lap -> IDLE with all digits 0.
REQ-035 Simultaneous: both buttons pressed in RUN in the same cycle -> PAUSE, o_lapHold unchanged.
REQ-036 Scan/reset: o_refreshSel sequence 0,1,2,0 with 4 cycles each, and o_digit equals the selected digit.
- Pull i_rst low mid-RUN with i_startStop held -> all outputs 0 immediately.
- After release, the module stays in IDLE until the button is released and pressed again.
